// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared types and defaults for the issue queue
// Element layout, boolean helpers and the default queue depth.
package issue_queue_pkg;

  typedef logic bool;
  localparam bool true  = 1'b1;
  localparam bool false = 1'b0;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/issue_queue_ram.sv
// rtl/issue_queue_ram.sv - DEPTH x element storage, two sync write and two async read ports
// Holds payload only; pointers and occupancy live in issue_queue.
module issue_queue_ram
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0_i,
  input  logic [AW-1:0]      waddr0_i,
  input  ISSUE_QUEUE_ELEMENT wdata0_i,
  input  logic               we1_i,
  input  logic [AW-1:0]      waddr1_i,
  input  ISSUE_QUEUE_ELEMENT wdata1_i,
  input  logic [AW-1:0]      raddr0_i,
  output ISSUE_QUEUE_ELEMENT rdata0_o,
  input  logic [AW-1:0]      raddr1_i,
  output ISSUE_QUEUE_ELEMENT rdata1_o
);

  ISSUE_QUEUE_ELEMENT mem_q [DEPTH];

  // The two write addresses are always distinct (tail and tail+1).
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - dual-entry in-order FIFO between decode and issue
// Optional ISSUE_QUEUE_BYPASS_EN forwards pushes straight to issue when empty.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flash,
  input  logic [1:0]               push_valid,
  input  ISSUE_QUEUE_ELEMENT [1:0] push_data,
  output logic                     push_ready,
  output ISSUE_QUEUE_ELEMENT [1:0] issue_require,
  output logic [1:0]               iq_size,
  input  logic [1:0]               iq_pop_number
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [AW:0]        count_q, count_d;
  logic [1:0]         push_n, pop_n, wr_n, head_adv, skip_n;
  logic               we0, we1;
  ISSUE_QUEUE_ELEMENT wdata0, rdata0, rdata1;

  assign push_ready = ((AW+1)'(DEPTH) - count_q) >= (AW+1)'(2);

  always_comb begin
    push_n = 2'd0;
    if (push_ready) begin
      if (push_valid == 2'b11)      push_n = 2'd2;
      else if (push_valid == 2'b01) push_n = 2'd1;
    end

    iq_size          = (count_q >= (AW+1)'(2)) ? 2'd2 : count_q[1:0];
    issue_require[0] = (iq_size != 2'd0) ? rdata0 : '0;
    issue_require[1] = (iq_size == 2'd2) ? rdata1 : '0;
    pop_n            = (iq_pop_number > iq_size) ? iq_size : iq_pop_number;
    skip_n           = 2'd0;
    wr_n             = push_n;
    head_adv         = pop_n;

`ifdef ISSUE_QUEUE_BYPASS_EN
    // Empty queue: pushes are visible now; popped ones never touch storage.
    if (count_q == '0 && !flash) begin
      iq_size          = push_n;
      issue_require[0] = (push_n != 2'd0) ? push_data[0] : '0;
      issue_require[1] = (push_n == 2'd2) ? push_data[1] : '0;
      pop_n            = (iq_pop_number > push_n) ? push_n : iq_pop_number;
      skip_n           = pop_n;
      wr_n             = push_n - pop_n;
      head_adv         = 2'd0;
    end
`endif

    we0    = !flash && (wr_n != 2'd0);
    we1    = !flash && (wr_n == 2'd2);
    wdata0 = (skip_n == 2'd1) ? push_data[1] : push_data[0];

    tail_d  = tail_q + AW'(wr_n);
    head_d  = head_q + AW'(head_adv);
    count_d = count_q + (AW+1)'(wr_n) - (AW+1)'(head_adv);
    if (flash) begin
      tail_d  = '0;
      head_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flash) begin
      assert (iq_pop_number <= iq_size)
        else $warning("issue_queue: pop number %0d exceeds size %0d, clamped", iq_pop_number, iq_size);
      assert (push_valid != 2'b10)
        else $warning("issue_queue: push_valid=10 ignored");
    end
  end

  issue_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + AW'(1)),
    .wdata1_i (push_data[1]),
    .raddr0_i (head_q),
    .rdata0_o (rdata0),
    .raddr1_i (head_q + AW'(1)),
    .rdata1_o (rdata1)
  );

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
// Bypass scenario is compiled in only with ISSUE_QUEUE_BYPASS_EN.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flash;
  logic [1:0]               push_valid;
  ISSUE_QUEUE_ELEMENT [1:0] push_data;
  logic                     push_ready;
  ISSUE_QUEUE_ELEMENT [1:0] issue_require;
  logic [1:0]               iq_size;
  logic [1:0]               iq_pop_number;

  int checks = 0;
  int errors = 0;

  issue_queue #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flash         (flash),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .issue_require (issue_require),
    .iq_size       (iq_size),
    .iq_pop_number (iq_pop_number)
  );

  always #5 clk = ~clk;

  function automatic ISSUE_QUEUE_ELEMENT mk(input int k);
    ISSUE_QUEUE_ELEMENT e;
    e.pc   = 32'h0000_1000 + 32'(k * 4);
    e.insn = 32'hC0DE_0000 + 32'(k);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid    = 2'b00;
    iq_pop_number = 2'd0;
    flash         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    push_data = '0;
    step();
    step();
    rst_n = 1'b1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", push_ready); end
    checks++; if (iq_size !== 2'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", iq_size); end
    checks++; if (issue_require !== '0) begin errors++; $display("FAIL reset_require: got %h expected 0", issue_require); end
  endtask

  task automatic test_push_pop();
    push_valid = 2'b11; push_data[0] = mk(1); push_data[1] = mk(2);
    step();
    idle();
    checks++; if (iq_size !== 2'd2) begin errors++; $display("FAIL pp_size2: got %0d expected 2", iq_size); end
    checks++; if (issue_require[0] !== mk(1)) begin errors++; $display("FAIL pp_head: got %h expected %h", issue_require[0], mk(1)); end
    checks++; if (issue_require[1] !== mk(2)) begin errors++; $display("FAIL pp_next: got %h expected %h", issue_require[1], mk(2)); end
    iq_pop_number = 2'd1;
    step();
    idle();
    checks++; if (iq_size !== 2'd1) begin errors++; $display("FAIL pp_size1: got %0d expected 1", iq_size); end
    checks++; if (issue_require[0] !== mk(2)) begin errors++; $display("FAIL pp_head_after_pop: got %h expected %h", issue_require[0], mk(2)); end
    checks++; if (issue_require[1] !== '0) begin errors++; $display("FAIL pp_empty_slot: got %h expected 0", issue_require[1]); end
    iq_pop_number = 2'd1;
    step();
    idle();
    checks++; if (iq_size !== 2'd0) begin errors++; $display("FAIL pp_drained: got %0d expected 0", iq_size); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, push_ready); end
      push_valid = 2'b11; push_data[0] = mk(10 + 2*i); push_data[1] = mk(11 + 2*i);
      step();
    end
    idle();
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b expected 0", push_ready); end
    push_valid = 2'b11; push_data[0] = mk(90); push_data[1] = mk(91);
    step();
    idle();
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_still_full: got %b expected 0", push_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (issue_require[0] !== mk(10 + 2*i)) begin errors++; $display("FAIL fill_drain0_%0d: got %h expected %h", i, issue_require[0], mk(10 + 2*i)); end
      checks++; if (issue_require[1] !== mk(11 + 2*i)) begin errors++; $display("FAIL fill_drain1_%0d: got %h expected %h", i, issue_require[1], mk(11 + 2*i)); end
      iq_pop_number = 2'd2;
      step();
      idle();
    end
    checks++; if (iq_size !== 2'd0) begin errors++; $display("FAIL fill_rejected_push: got size %0d expected 0", iq_size); end
  endtask

  task automatic test_back_to_back();
    push_valid = 2'b11; push_data[0] = mk(100); push_data[1] = mk(101);
    step();
    for (int i = 0; i < 20; i++) begin
      push_valid = 2'b11; push_data[0] = mk(102 + 2*i); push_data[1] = mk(103 + 2*i);
      iq_pop_number = 2'd2;
      checks++; if (iq_size !== 2'd2) begin errors++; $display("FAIL b2b_size_%0d: got %0d expected 2", i, iq_size); end
      checks++; if (issue_require[0] !== mk(100 + 2*i) || issue_require[1] !== mk(101 + 2*i)) begin
        errors++; $display("FAIL b2b_order_%0d: got %h expected %h_%h", i, issue_require, mk(101 + 2*i), mk(100 + 2*i));
      end
      step();
    end
    idle();
    iq_pop_number = 2'd2;
    step();
    idle();
    checks++; if (iq_size !== 2'd0 || push_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: got size %0d ready %b expected 0 1", iq_size, push_ready); end
  endtask

  task automatic test_flush();
    push_valid = 2'b11; push_data[0] = mk(200); push_data[1] = mk(201); step();
    push_data[0] = mk(202); push_data[1] = mk(203); step();
    push_valid = 2'b01; push_data[0] = mk(204); step();
    push_valid = 2'b01; push_data[0] = mk(205); flash = 1'b1;
    step();
    idle();
    checks++; if (iq_size !== 2'd0) begin errors++; $display("FAIL flush_size: got %0d expected 0", iq_size); end
    checks++; if (issue_require !== '0) begin errors++; $display("FAIL flush_require: got %h expected 0", issue_require); end
    push_valid = 2'b01; push_data[0] = mk(206);
    step();
    idle();
    checks++; if (issue_require[0] !== mk(206) || iq_size !== 2'd1) begin
      errors++; $display("FAIL flush_after: got %h size %0d expected %h size 1", issue_require[0], iq_size, mk(206));
    end
    iq_pop_number = 2'd1; step(); idle();
  endtask

  task automatic test_overpop();
    push_valid = 2'b01; push_data[0] = mk(300);
    step();
    idle();
    iq_pop_number = 2'd2;
    step();
    idle();
    checks++; if (iq_size !== 2'd0 || push_ready !== 1'b1) begin errors++; $display("FAIL overpop_clamp: got size %0d ready %b expected 0 1", iq_size, push_ready); end
    push_valid = 2'b10; push_data[0] = mk(301); push_data[1] = mk(302);
    step();
    idle();
    checks++; if (iq_size !== 2'd0) begin errors++; $display("FAIL illegal_valid: got size %0d expected 0", iq_size); end
    push_valid = 2'b01; push_data[0] = mk(303);
    step();
    idle();
    checks++; if (issue_require[0] !== mk(303) || iq_size !== 2'd1) begin
      errors++; $display("FAIL overpop_next: got %h size %0d expected %h size 1", issue_require[0], iq_size, mk(303));
    end
    iq_pop_number = 2'd1; step(); idle();
  endtask

  task automatic test_bypass();
`ifdef ISSUE_QUEUE_BYPASS_EN
    push_valid = 2'b11; push_data[0] = mk(400); push_data[1] = mk(401);
    iq_pop_number = 2'd1;
    #1;
    checks++; if (issue_require[0] !== mk(400) || iq_size !== 2'd2) begin
      errors++; $display("FAIL bypass_same_cycle: got %h size %0d expected %h size 2", issue_require[0], iq_size, mk(400));
    end
    step();
    idle();
    #1;
    checks++; if (issue_require[0] !== mk(401) || iq_size !== 2'd1) begin
      errors++; $display("FAIL bypass_remainder: got %h size %0d expected %h size 1", issue_require[0], iq_size, mk(401));
    end
    iq_pop_number = 2'd1; step(); idle();
`endif
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_fill();
    test_back_to_back();
    test_flush();
    test_overpop();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
